// File: rtl/updown_counter_ctl.sv
// Bounded up/down counter with step, wrap/saturate, load and sticky flags.
// Count, tc, ovf and udf are registered; at_hi/at_lo/cfg_err are combinational.
module updown_counter_ctl #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic [WIDTH-1:0]  lo,
   input  logic [WIDTH-1:0]  hi,
   input  logic              sat,
   input  logic              clr_flags,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              ovf,
   output logic              udf,
   output logic              at_hi,
   output logic              at_lo,
   output logic              cfg_err
);

   // One guard bit above the wider of count and step keeps sums exact.
   localparam int SW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

   logic [SW-1:0]    cnt_x;
   logic [SW-1:0]    lo_x;
   logic [SW-1:0]    hi_x;
   logic [SW-1:0]    stp_x;
   logic [SW-1:0]    sum_up;
   logic [SW-1:0]    lo_plus;
   logic             stepping;
   logic             out_rng;
   logic             up_cross;
   logic             dn_cross;
   logic [WIDTH-1:0] count_d;
   logic             tc_d;
   logic             ovf_d;
   logic             udf_d;

   assign at_hi   = (count == hi);
   assign at_lo   = (count == lo);
   assign cfg_err = (lo > hi);

   // Widened operands and crossing detection.
   always_comb begin
      cnt_x    = SW'(count);
      lo_x     = SW'(lo);
      hi_x     = SW'(hi);
      stp_x    = SW'(step);
      sum_up   = cnt_x + stp_x;
      lo_plus  = lo_x + stp_x;
      stepping = en && (step != '0);
      out_rng  = (count < lo) || (count > hi);
      up_cross = (sum_up > hi_x);
      dn_cross = (cnt_x < lo_plus);
   end

   // Next-state selection in priority order: cfg hold, load, step.
   always_comb begin
      count_d = count;
      tc_d    = 1'b0;
      ovf_d   = ovf && !clr_flags;
      udf_d   = udf && !clr_flags;
      priority case (1'b1)
         cfg_err: begin
            count_d = count;
         end
         load: begin
            if (load_val < lo)
               count_d = lo;
            else if (load_val > hi)
               count_d = hi;
            else
               count_d = load_val;
         end
         (stepping && out_rng): begin
            count_d = lo;
         end
         (stepping && up): begin
            if (up_cross) begin
               count_d = sat ? hi : lo;
               tc_d    = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               count_d = sum_up[WIDTH-1:0];
            end
         end
         (stepping && !up): begin
            if (dn_cross) begin
               count_d = sat ? lo : hi;
               tc_d    = 1'b1;
               udf_d   = 1'b1;
            end else begin
               count_d = count - WIDTH'(step);
            end
         end
         default: begin
            count_d = count;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         tc    <= 1'b0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         count <= count_d;
         tc    <= tc_d;
         ovf   <= ovf_d;
         udf   <= udf_d;
      end
   end

endmodule

// File: tb/tb_updown_counter_ctl.sv
// Bench for updown_counter_ctl: directed vector table then random
// stimulus against an integer reference model.
module tb_updown_counter_ctl;

   localparam int WIDTH  = 8;
   localparam int STEP_W = 4;

   logic              clk;
   logic              reset;
   logic              en;
   logic              up;
   logic [STEP_W-1:0] step;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic [WIDTH-1:0]  lo;
   logic [WIDTH-1:0]  hi;
   logic              sat;
   logic              clr_flags;
   logic [WIDTH-1:0]  count;
   logic              tc;
   logic              ovf;
   logic              udf;
   logic              at_hi;
   logic              at_lo;
   logic              cfg_err;

   updown_counter_ctl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk(clk), .reset(reset), .en(en), .up(up), .step(step),
      .load(load), .load_val(load_val), .lo(lo), .hi(hi), .sat(sat),
      .clr_flags(clr_flags), .count(count), .tc(tc), .ovf(ovf),
      .udf(udf), .at_hi(at_hi), .at_lo(at_lo), .cfg_err(cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int rst; int ld; int lv; int en; int up; int st;
      int lo; int hi; int sat; int clr;
      int ec; int et; int eo; int eu;
   } vec_t;

   vec_t tab[$];
   int   n_vec = 0;
   int   n_err = 0;

   int m_count = 0;
   int m_tc    = 0;
   int m_ovf   = 0;
   int m_udf   = 0;

   function automatic vec_t mk(int rst, int ld, int lv, int e, int u,
                               int st, int l, int h, int s, int c,
                               int ec, int et, int eo, int eu);
      vec_t v;
      v.rst = rst; v.ld = ld; v.lv = lv; v.en = e; v.up = u;
      v.st = st; v.lo = l; v.hi = h; v.sat = s; v.clr = c;
      v.ec = ec; v.et = et; v.eo = eo; v.eu = eu;
      return v;
   endfunction

   // Reference model: plain integer arithmetic over the counting rules.
   function automatic void model_step(vec_t v);
      int nc, nt, no, nu;
      if (v.rst != 0) begin
         m_count = 0; m_tc = 0; m_ovf = 0; m_udf = 0;
         return;
      end
      nc = m_count;
      nt = 0;
      no = (v.clr != 0) ? 0 : m_ovf;
      nu = (v.clr != 0) ? 0 : m_udf;
      if (v.lo > v.hi) begin
         nc = m_count;
      end else if (v.ld != 0) begin
         if (v.lv < v.lo) nc = v.lo;
         else if (v.lv > v.hi) nc = v.hi;
         else nc = v.lv;
      end else if (v.en != 0 && v.st > 0) begin
         if (m_count < v.lo || m_count > v.hi) begin
            nc = v.lo;
         end else if (v.up != 0) begin
            if (m_count + v.st <= v.hi) nc = m_count + v.st;
            else begin
               nc = (v.sat != 0) ? v.hi : v.lo;
               nt = 1; no = 1;
            end
         end else begin
            if (m_count - v.st >= v.lo) nc = m_count - v.st;
            else begin
               nc = (v.sat != 0) ? v.lo : v.hi;
               nt = 1; nu = 1;
            end
         end
      end
      m_count = nc; m_tc = nt; m_ovf = no; m_udf = nu;
   endfunction

   task automatic apply(input vec_t v);
      reset     = (v.rst != 0);
      load      = (v.ld != 0);
      load_val  = WIDTH'(v.lv);
      en        = (v.en != 0);
      up        = (v.up != 0);
      step      = STEP_W'(v.st);
      lo        = WIDTH'(v.lo);
      hi        = WIDTH'(v.hi);
      sat       = (v.sat != 0);
      clr_flags = (v.clr != 0);
      model_step(v);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input vec_t v, input int ec,
                        input int et, input int eo, input int eu);
      logic [WIDTH+5:0] got;
      logic [WIDTH+5:0] exp;
      got = {count, tc, ovf, udf, at_hi, at_lo, cfg_err};
      exp = {WIDTH'(ec), et[0], eo[0], eu[0], (ec == v.hi),
             (ec == v.lo), (v.lo > v.hi)};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b udf=%0b ahi=%0b alo=%0b cfg=%0b, want cnt=%0d tc=%0d ovf=%0d udf=%0d ahi=%0b alo=%0b cfg=%0b",
                  name, count, tc, ovf, udf, at_hi, at_lo, cfg_err,
                  ec, et, eo, eu, (ec == v.hi), (ec == v.lo), (v.lo > v.hi));
      end
   endtask

   initial begin
      vec_t v;
      // rst ld lv en up st lo hi sat clr | count tc ovf udf
      tab.push_back(mk(1,0,0,  0,0,1, 0,255,0,0,   0,0,0,0));
      tab.push_back(mk(0,1,254,0,0,1, 0,255,0,0, 254,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,1, 0,255,0,0, 255,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,1, 0,255,0,0,   0,1,1,0));
      tab.push_back(mk(0,0,0,  1,1,1, 0,255,0,0,   1,0,1,0));
      tab.push_back(mk(0,0,0,  1,0,1, 0,255,0,0,   0,0,1,0));
      tab.push_back(mk(0,0,0,  1,0,1, 0,255,0,0, 255,1,1,1));
      tab.push_back(mk(0,1,10, 0,0,3,10,20,0,1,   10,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,3,10,20,0,0,   13,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,3,10,20,0,0,   16,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,3,10,20,0,0,   19,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,3,10,20,0,0,   10,1,1,0));
      tab.push_back(mk(0,1,19, 0,0,3,10,20,0,0,   19,0,1,0));
      tab.push_back(mk(0,0,0,  1,1,3,10,20,1,0,   20,1,1,0));
      tab.push_back(mk(0,0,0,  1,1,3,10,20,1,0,   20,1,1,0));
      tab.push_back(mk(0,1,12, 0,0,3,10,20,0,0,   12,0,1,0));
      tab.push_back(mk(0,0,0,  1,0,3,10,20,0,0,   20,1,1,1));
      tab.push_back(mk(0,1,5,  0,0,3,10,20,0,0,   10,0,1,1));
      tab.push_back(mk(0,1,99, 0,0,3,10,20,0,0,   20,0,1,1));
      tab.push_back(mk(0,1,15, 1,1,3,10,20,0,0,   15,0,1,1));
      tab.push_back(mk(0,0,0,  0,0,3,10,20,0,1,   15,0,0,0));
      tab.push_back(mk(0,1,19, 0,0,3,10,20,0,0,   19,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,3,10,20,0,0,   10,1,1,0));
      tab.push_back(mk(0,1,19, 0,0,3,10,20,0,0,   19,0,1,0));
      tab.push_back(mk(0,0,0,  1,1,3,10,20,0,1,   10,1,1,0));
      tab.push_back(mk(0,0,0,  0,0,3,10,20,0,1,   10,0,0,0));
      tab.push_back(mk(0,1,25, 0,0,1,10,40,0,0,   25,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,1,30,20,0,0,   25,0,0,0));
      tab.push_back(mk(0,1,35, 0,0,1,30,20,0,0,   25,0,0,0));
      tab.push_back(mk(0,0,0,  1,0,1,30,20,0,0,   25,0,0,0));
      tab.push_back(mk(0,1,22, 1,1,1,30,20,0,0,   25,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,1,30,20,1,0,   25,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,1,30,40,0,0,   30,0,0,0));
      tab.push_back(mk(0,1,255,0,0,1, 0,255,0,0, 255,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,1, 0,255,0,0,   0,1,1,0));
      tab.push_back(mk(0,1,76, 0,0,1, 0,255,0,0,  76,0,1,0));
      tab.push_back(mk(0,0,0,  1,1,1, 0,255,0,0,  77,0,1,0));
      tab.push_back(mk(1,1,200,1,1,1, 0,255,0,0,   0,0,0,0));
      tab.push_back(mk(0,0,0,  1,1,1, 0,255,0,0,   1,0,0,0));

      foreach (tab[i]) begin
         apply(tab[i]);
         check($sformatf("vec%0d", i), tab[i],
               tab[i].ec, tab[i].et, tab[i].eo, tab[i].eu);
      end

      v = mk(0,0,0,0,0,1,0,255,0,0,0,0,0,0);
      for (int i = 0; i < 400; i++) begin
         if (i % 25 == 0) begin
            v.lo = $urandom_range(0, 120);
            v.hi = $urandom_range(0, 255);
            v.sat = $urandom_range(0, 1);
         end
         v.rst = ($urandom_range(0, 63) == 0) ? 1 : 0;
         v.ld  = ($urandom_range(0, 7) == 0) ? 1 : 0;
         v.lv  = $urandom_range(0, 255);
         v.en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
         v.up  = $urandom_range(0, 1);
         v.st  = $urandom_range(0, 15);
         v.clr = ($urandom_range(0, 15) == 0) ? 1 : 0;
         apply(v);
         check($sformatf("rnd%0d", i), v, m_count, m_tc, m_ovf, m_udf);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
